// File: rtl/spike_send_scheduler.sv
// -----------------------------------------------------------------------------
// spike_send_scheduler
//
// Per-tick drain controller between a core's outgoing-spike FIFO and the
// router link. Each tick starts a drain round. The round pops packets one at a
// time and presents each packet on a valid/ready port. A round ends when one
// of these happens:
//   - the FIFO is empty at a decision point, or
//   - the per-tick budget MAX_PER_TICK has been used up.
// Budget exhaustion with data still queued sets a sticky flag. A tick that
// arrives while a round is in progress also sets a sticky flag.
//
// Parameters
//   PACKET_WIDTH  width of one spike packet (opaque payload)
//   MAX_PER_TICK  packets allowed per round, >= 1
//   CNT_W         width of sent_count
//
// Ports
//   clk          clock
//   rst          synchronous, active-high reset
//   tick         1-cycle strobe that starts a drain round
//   err_clr      clears the sticky error flags
//   buf_empty    FIFO empty flag
//   buf_ren      FIFO read enable, 1-cycle pulse
//   buf_data     FIFO read data, valid the cycle after buf_ren
//   pkt_out      packet to the router (0 whenever pkt_valid is low)
//   pkt_valid    pkt_out valid
//   pkt_ready    router accepts when pkt_valid & pkt_ready
//   busy         high whenever a round is in progress
//   tick_done    1-cycle pulse that closes each round
//   sent_count   packets accepted in the current or last round
//   budget_err   sticky: budget reached with the FIFO still non-empty
//   overrun_err  sticky: tick arrived while busy
// -----------------------------------------------------------------------------
module spike_send_scheduler #(
  parameter int PACKET_WIDTH = 32,
  parameter int MAX_PER_TICK = 256,
  parameter int CNT_W        = $clog2(MAX_PER_TICK + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic                    err_clr,
  input  logic                    buf_empty,
  output logic                    buf_ren,
  input  logic [PACKET_WIDTH-1:0] buf_data,
  output logic [PACKET_WIDTH-1:0] pkt_out,
  output logic                    pkt_valid,
  input  logic                    pkt_ready,
  output logic                    busy,
  output logic                    tick_done,
  output logic [CNT_W-1:0]        sent_count,
  output logic                    budget_err,
  output logic                    overrun_err
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,  // waiting for a tick
    READ = 3'd1,  // FIFO pop issued this cycle
    WAIT = 3'd2,  // FIFO data arrives; captured at the end of this cycle
    SEND = 3'd3,  // packet presented, waiting for acceptance
    DONE = 3'd4   // round closed, tick_done pulses
  } state_t;

  state_t state;
  state_t state_nxt;

  localparam logic [CNT_W-1:0] BUDGET = CNT_W'(MAX_PER_TICK);

  // ---------------------------------------------------------------------------
  // Event decode
  // ---------------------------------------------------------------------------
  logic             accept;       // handshake completes at this edge
  logic [CNT_W-1:0] count_inc;    // sent_count after this acceptance
  logic             budget_hit;   // this acceptance uses the last budget slot
  logic             round_start;  // tick accepted from IDLE
  logic             overrun_evt;  // tick while a round is in progress
  logic             budget_evt;   // budget used up with data still queued

  // pkt_valid is only ever high in SEND, but qualify by state anyway so the
  // counters can never move outside a round.
  assign accept      = (state == SEND) && pkt_valid && pkt_ready;
  assign count_inc   = sent_count + CNT_W'(1);
  assign budget_hit  = (count_inc == BUDGET);
  assign round_start = (state == IDLE) && tick;
  // DONE counts as busy, so a tick on the tick_done cycle is an overrun.
  assign overrun_evt = tick && (state != IDLE);
  assign budget_evt  = accept && budget_hit && !buf_empty;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: rst is sampled only on the clock edge (synchronous reset). Every
  // register in this block uses the same if (rst) ... else ... shape. All
  // sequential state is written with non-blocking assignments. This keeps
  // registers that read each other order-independent within a clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_nxt gets a default before the case statement. Any path that
  // does not assign it then holds the current state, and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (tick) begin
          state_nxt = buf_empty ? DONE : READ;
        end
      end
      READ: state_nxt = WAIT;
      WAIT: state_nxt = SEND;
      SEND: begin
        if (accept) begin
          // The budget check takes priority over the empty check. Data that
          // is still queued stays in the FIFO for the next round.
          if (budget_hit || buf_empty) begin
            state_nxt = DONE;
          end else begin
            state_nxt = READ;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State-decoded outputs
  // ---------------------------------------------------------------------------
  // buf_ren comes only from READ. READ is entered only after buf_empty was
  // seen low, and only once the previous packet has been accepted. A pop
  // therefore never hits an empty FIFO and never overlaps a held packet.
  always_comb begin
    buf_ren   = (state == READ);
    busy      = (state != IDLE);
    tick_done = (state == DONE);
  end

  // ---------------------------------------------------------------------------
  // Packet holding register
  // ---------------------------------------------------------------------------
  // The packet is loaded in WAIT, one cycle after the pop. It is held
  // unchanged while the router stalls, and cleared on acceptance so that
  // pkt_out reads 0 whenever pkt_valid is low. A reset in the middle of a
  // round drops the held packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_out   <= '0;
      pkt_valid <= 1'b0;
    end else if (state == WAIT) begin
      pkt_out   <= buf_data;
      pkt_valid <= 1'b1;
    end else if (accept) begin
      pkt_out   <= '0;
      pkt_valid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-round accepted-packet counter
  // ---------------------------------------------------------------------------
  // The counter is cleared only when a tick is accepted from IDLE. Its value
  // stays visible after tick_done until the next round starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      sent_count <= '0;
    end else if (round_start) begin
      sent_count <= '0;
    end else if (accept) begin
      sent_count <= count_inc;
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags
  // ---------------------------------------------------------------------------
  // The set condition is tested before err_clr. A clear that coincides with
  // a new error event therefore leaves the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      budget_err  <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      if (budget_evt) begin
        budget_err <= 1'b1;
      end else if (err_clr) begin
        budget_err <= 1'b0;
      end

      if (overrun_evt) begin
        overrun_err <= 1'b1;
      end else if (err_clr) begin
        overrun_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spike_send_scheduler.sv
// -----------------------------------------------------------------------------
// tb_spike_send_scheduler
//
// Bench for spike_send_scheduler, built with a small budget (MAX_PER_TICK=4).
//
// The bench owns a FIFO model (a queue). That model answers buf_ren with
// data one cycle later and drives unrelated random data on buf_data at all
// other times.
//
// The reference model works at the level of drain rounds:
//   - A round starts on a tick while idle and ends on tick_done.
//   - A round must send min(budget, packets available) packets.
//   - Accepted packets must come out in FIFO order.
//   - Flags are set by the events defined for them: a tick while a round is
//     running, or budget exhausted with data still queued.
//   - err_clr clears the flags, except that a set in the same cycle wins.
//
// All stimulus and sampling happen on the falling edge. FIFO pops happen on
// the rising edge, using non-blocking updates.
// -----------------------------------------------------------------------------
module tb_spike_send_scheduler;

  localparam int PW  = 32;
  localparam int MAX = 4;
  localparam int CW  = $clog2(MAX + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          tick;
  logic          err_clr;
  logic          buf_empty;
  logic          buf_ren;
  logic [PW-1:0] buf_data;
  logic [PW-1:0] pkt_out;
  logic          pkt_valid;
  logic          pkt_ready;
  logic          busy;
  logic          tick_done;
  logic [CW-1:0] sent_count;
  logic          budget_err;
  logic          overrun_err;

  always #5 clk = ~clk;

  spike_send_scheduler #(
    .PACKET_WIDTH (PW),
    .MAX_PER_TICK (MAX)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .err_clr     (err_clr),
    .buf_empty   (buf_empty),
    .buf_ren     (buf_ren),
    .buf_data    (buf_data),
    .pkt_out     (pkt_out),
    .pkt_valid   (pkt_valid),
    .pkt_ready   (pkt_ready),
    .busy        (busy),
    .tick_done   (tick_done),
    .sent_count  (sent_count),
    .budget_err  (budget_err),
    .overrun_err (overrun_err)
  );

  // ---------------------------------------------------------------------------
  // Bench state and reference model
  // ---------------------------------------------------------------------------
  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;

  logic [PW-1:0] fifo_q[$];    // packets still in the FIFO
  logic [PW-1:0] popped_q[$];  // popped by the DUT, not yet accepted

  bit            in_round        = 1'b0;
  int            round_acc       = 0;  // accepted in the current or last round
  int            n_at_tick       = 0;  // FIFO occupancy when the round began
  int            pushed_in_round = 0;
  bit            exp_ovr         = 1'b0;
  bit            exp_bud         = 1'b0;
  bit            rst_prev        = 1'b0;
  bit            prev_stall      = 1'b0;
  logic [PW-1:0] prev_pkt        = '0;
  bit            prev_valid      = 1'b0;
  bit            saw_ren         = 1'b0;
  bit            saw_done        = 1'b0;

  bit            trace = 1'b0;
  int            t0    = 0;
  int            ren_log[$];
  int            val_log[$];
  int            done_log[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic push(input logic [PW-1:0] d);
    fifo_q.push_back(d);
    buf_empty = 1'b0;
    if (in_round) pushed_in_round++;
  endtask

  task automatic clear_logs();
    ren_log.delete();
    val_log.delete();
    done_log.delete();
  endtask

  // Compare the outputs of the current cycle against the model.
  task automatic observe();
    saw_ren  = (buf_ren === 1'b1);
    saw_done = (tick_done === 1'b1);
    if (rst_prev) begin
      check("rst_pkt_valid",   pkt_valid,   0);
      check("rst_pkt_out",     pkt_out,     0);
      check("rst_busy",        busy,        0);
      check("rst_tick_done",   tick_done,   0);
      check("rst_buf_ren",     buf_ren,     0);
      check("rst_sent_count",  sent_count,  0);
      check("rst_budget_err",  budget_err,  0);
      check("rst_overrun_err", overrun_err, 0);
      popped_q.delete();
      rst_prev = 1'b0;
    end else begin
      check("busy",        busy,        in_round);
      check("overrun_err", overrun_err, exp_ovr);
      check("budget_err",  budget_err,  exp_bud);
      check("sent_count",  sent_count,  round_acc);
      if (pkt_valid !== 1'b1) check("pkt_out_zero_when_invalid", pkt_out, 0);
      if (prev_stall) begin
        check("stall_valid_held", pkt_valid, 1);
        check("stall_data_held",  pkt_out,   prev_pkt);
      end
      if (saw_ren) check("ren_while_valid", pkt_valid, 0);
      if (saw_done) begin
        check("done_inside_round", in_round, 1);
        check("round_sent", round_acc, min_i(MAX, n_at_tick + pushed_in_round));
      end
    end
    if (trace) begin
      if (saw_ren) ren_log.push_back(cyc - t0);
      if (pkt_valid === 1'b1 && !prev_valid) val_log.push_back(cyc - t0);
      if (saw_done) done_log.push_back(cyc - t0);
    end
    prev_valid = (pkt_valid === 1'b1);
  endtask

  // One clock cycle. The sequence is:
  //   1. observe the outputs;
  //   2. drive the inputs for the coming edge;
  //   3. advance the model;
  //   4. serve a FIFO pop at the edge.
  task automatic step(input bit t, input bit clr, input bit rdy, input bit r);
    bit set_ovr;
    bit set_bud;
    observe();
    tick      = t;
    err_clr   = clr;
    pkt_ready = rdy;
    rst       = r;
    set_ovr   = 1'b0;
    set_bud   = 1'b0;
    if (r) begin
      in_round   = 1'b0;
      round_acc  = 0;
      exp_ovr    = 1'b0;
      exp_bud    = 1'b0;
      prev_stall = 1'b0;
      rst_prev   = 1'b1;
    end else begin
      if (pkt_valid === 1'b1 && rdy) begin
        check("one_packet_in_flight", popped_q.size(), 1);
        if (popped_q.size() > 0) check("pkt_data_order", pkt_out, popped_q.pop_front());
        round_acc++;
        if (round_acc == MAX && fifo_q.size() != 0) set_bud = 1'b1;
      end
      if (t) begin
        if (in_round) begin
          set_ovr = 1'b1;
        end else begin
          in_round        = 1'b1;
          round_acc       = 0;
          n_at_tick       = fifo_q.size();
          pushed_in_round = 0;
          if (trace) t0 = cyc;
        end
      end
      if (saw_done) in_round = 1'b0;
      exp_ovr    = set_ovr | (exp_ovr & ~clr);
      exp_bud    = set_bud | (exp_bud & ~clr);
      prev_stall = (pkt_valid === 1'b1) && !rdy;
      prev_pkt   = pkt_out;
    end
    @(posedge clk);
    if (saw_ren) begin
      check("ren_fifo_nonempty", 64'(fifo_q.size() != 0), 1);
      if (fifo_q.size() != 0) begin
        buf_data <= fifo_q[0];
        popped_q.push_back(fifo_q[0]);
        fifo_q.pop_front();
      end
      buf_empty <= (fifo_q.size() == 0);
    end else begin
      buf_data <= $urandom();
    end
    @(negedge clk);
    cyc++;
  endtask

  // Finish the current round.
  //   mode 0: pkt_ready is tied high.
  //   mode 1: pkt_ready, stray ticks and err_clr are all random.
  task automatic run_until_done(input int mode, input int limit);
    int n;
    bit rdy;
    bit t;
    bit c;
    n = 0;
    while (in_round && n < limit) begin
      rdy = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      t   = (mode == 1) && ($urandom_range(0, 15) == 0);
      c   = (mode == 1) && ($urandom_range(0, 15) == 0);
      step(t, c, rdy, 1'b0);
      n++;
    end
    check("round_timeout", in_round, 0);
    if (in_round) step(1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [PW-1:0] a;
    logic [PW-1:0] b;
    rst       = 1'b1;
    tick      = 1'b0;
    err_clr   = 1'b0;
    pkt_ready = 1'b0;
    buf_empty = 1'b1;
    buf_data  = '0;
    repeat (3) @(negedge clk);
    rst_prev = 1'b1;
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);

    // Three packets, ready tied high. Expected offsets from the tick edge:
    // ren at 1/4/7, valid at 3/6/9, tick_done at 10.
    clear_logs();
    trace = 1'b1;
    push(32'hA0A0_0001);
    push(32'hB0B0_0002);
    push(32'hC0C0_0003);
    step(1, 0, 1, 0);
    run_until_done(0, 50);
    trace = 1'b0;
    check("t1_ren_count", ren_log.size(), 3);
    check("t1_val_count", val_log.size(), 3);
    for (int i = 0; i < min_i(3, ren_log.size()); i++) check("t1_ren_cycle", ren_log[i], 1 + 3 * i);
    for (int i = 0; i < min_i(3, val_log.size()); i++) check("t1_valid_cycle", val_log[i], 3 + 3 * i);
    check("t1_done_count", done_log.size(), 1);
    if (done_log.size() > 0) check("t1_done_cycle", done_log[0], 10);
    check("t1_sent_count", sent_count, 3);
    check("t1_fifo_left", fifo_q.size(), 0);

    // Empty FIFO: a single DONE cycle, no pop, no valid.
    clear_logs();
    trace = 1'b1;
    step(1, 0, 1, 0);
    run_until_done(0, 10);
    trace = 1'b0;
    check("t2_ren_count", ren_log.size(), 0);
    check("t2_val_count", val_log.size(), 0);
    check("t2_done_count", done_log.size(), 1);
    if (done_log.size() > 0) check("t2_done_cycle", done_log[0], 1);
    check("t2_sent_count", sent_count, 0);
    // A tick in the DONE cycle is an overrun.
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    step(0, 0, 1, 0);
    check("t2_overrun_in_done", overrun_err, 1);
    step(0, 1, 1, 0);
    step(0, 0, 1, 0);

    // Budget: 6 queued with a budget of 4. The first round stops at 4 and
    // flags the error; the next round drains the last 2; the flag persists.
    for (int i = 0; i < 6; i++) push($urandom());
    step(1, 0, 1, 0);
    run_until_done(0, 60);
    step(0, 0, 1, 0);
    check("t3_budget_err", budget_err, 1);
    check("t3_fifo_left", fifo_q.size(), 2);
    step(1, 0, 1, 0);
    run_until_done(0, 60);
    step(0, 0, 1, 0);
    check("t3_budget_sticky", budget_err, 1);
    check("t3_fifo_drained", fifo_q.size(), 0);
    step(0, 1, 1, 0);
    step(0, 0, 1, 0);

    // Router stall: the packet is held while ready is low, then sent once.
    a = 32'h1234_5678;
    push(a);
    step(1, 0, 0, 0);
    repeat (8) step(0, 0, 0, 0);
    check("t4_valid_stalled", pkt_valid, 1);
    check("t4_data_stalled", pkt_out, a);
    run_until_done(0, 20);
    check("t4_sent_count", sent_count, 1);

    // A second tick during SEND is ignored but flags an overrun.
    push($urandom());
    push($urandom());
    step(1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    run_until_done(0, 40);
    step(0, 0, 1, 0);
    check("t5_overrun_set", overrun_err, 1);
    check("t5_sent_count", sent_count, 2);
    step(0, 1, 1, 0);
    step(0, 0, 1, 0);
    check("t5_overrun_clr", overrun_err, 0);
    // An overrun in the same cycle as err_clr: the set wins.
    push($urandom());
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    run_until_done(0, 20);
    step(0, 0, 1, 0);
    check("t5_set_beats_clr", overrun_err, 1);
    step(0, 1, 1, 0);

    // Reset in WAIT: the held packet is dropped and the flags clear. The
    // next tick drains what remains in the FIFO.
    push($urandom());
    push($urandom());
    push($urandom());
    step(1, 0, 1, 0);
    check("t6_ren_before_reset", buf_ren, 1);
    step(1, 0, 1, 0);
    step(0, 0, 1, 1);
    step(0, 0, 1, 0);
    check("t6_valid_after_rst", pkt_valid, 0);
    check("t6_busy_after_rst", busy, 0);
    check("t6_fifo_left", fifo_q.size(), 2);
    step(1, 0, 1, 0);
    run_until_done(0, 40);
    check("t6_sent_after_rst", sent_count, 2);
    check("t6_fifo_drained", fifo_q.size(), 0);

    // A FIFO write during a round is drained in the same round.
    b = 32'hFEED_0001;
    push(b);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    push(32'hFEED_0002);
    step(0, 0, 1, 0);
    run_until_done(0, 30);
    check("t7_sent_count", sent_count, 2);

    // Random rounds: random packet mixes, router backpressure, stray
    // ticks and err_clr pulses.
    for (int r = 0; r < 40; r++) begin
      int k;
      if (fifo_q.size() < 8) begin
        k = $urandom_range(0, 5);
        for (int i = 0; i < k; i++) push($urandom());
      end
      if ($urandom_range(0, 3) == 0) step(0, 1, 1, 0);
      step(1, 0, 1'($urandom_range(0, 1)), 0);
      run_until_done(1, 400);
    end
    step(0, 0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
